approx_err_sweep: RTL and testbench

APPROX_ERR_SWEEP -- requirements
Module: approx_err_sweep

---
 rtl/approx_err_sweep_pkg.sv | 12 +
 rtl/approx_err_sweep_err_accum.sv | 109 ++++++++++
 rtl/approx_err_sweep.sv | 81 ++++++++
 tb/tb_approx_err_sweep.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_err_sweep_pkg.sv
// approx_err_sweep_pkg: FSM state type and datapath widths shared by the
// exhaustive multiplier error sweep and its compare/accumulate datapath.
package approx_err_sweep_pkg;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FIN} state_e;
   localparam int N_PAIRS   = 256;
   localparam int CNT_W     = 8;
   localparam int DRAIN_W   = 3;
   localparam int ERR_CNT_W = 9;
   localparam int SUM_ABS_W = 16;
   localparam int MAX_ERR_W = 8;
   localparam int SUM_ERR_W = 17;
endpackage

// File: rtl/approx_err_sweep_err_accum.sv
// err_accum: delays each operand pair alongside the multiplier latency, registers
// exact product / approximate result / signed difference, then accumulates statistics.
module err_accum
   import approx_err_sweep_pkg::*;
#(
   parameter int LAT = 0,
   parameter int W   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        in_vld,
   input  logic [W-1:0]                in_a,
   input  logic [W-1:0]                in_b,
   input  logic [2*W-1:0]              mul_r,
   output logic [ERR_CNT_W-1:0]        err_count,
   output logic [SUM_ABS_W-1:0]        sum_abs_err,
   output logic [MAX_ERR_W-1:0]        max_abs_err,
   output logic signed [SUM_ERR_W-1:0] sum_err
);
   localparam int PW = 2 * W;
   localparam int DW = PW + 1;
   localparam int TW = 2 * W + 1;

   logic [TW-1:0]               tag_in, tag_out;
   logic                        t_vld;
   logic [W-1:0]                t_a, t_b;
   logic                        cmp_vld_d, cmp_vld_q;
   logic [PW-1:0]               prod_d, prod_q, res_d, res_q;
   logic signed [DW-1:0]        diff_d, diff_q;
   logic [MAX_ERR_W-1:0]        abs_err;
   logic [ERR_CNT_W-1:0]        err_count_d, err_count_q;
   logic [SUM_ABS_W-1:0]        sum_abs_err_d, sum_abs_err_q;
   logic [MAX_ERR_W-1:0]        max_abs_err_d, max_abs_err_q;
   logic signed [SUM_ERR_W-1:0] sum_err_d, sum_err_q;

   assign tag_in = {in_vld, in_a, in_b};

   generate
      if (LAT == 0) begin : g_direct
         assign tag_out = tag_in;
      end else begin : g_pipe
         logic [TW-1:0] pipe_d [LAT];
         logic [TW-1:0] pipe_q [LAT];
         always_comb begin
            pipe_d[0] = clr ? '0 : tag_in;
            for (int i = 1; i < LAT; i++) pipe_d[i] = clr ? '0 : pipe_q[i-1];
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
            else pipe_q <= pipe_d;
         end
         assign tag_out = pipe_q[LAT-1];
      end
   endgenerate

   assign {t_vld, t_a, t_b} = tag_out;

   // |diff| never exceeds 255 (mul_r <= 255, product >= 0), so truncation is lossless
   always_comb begin
      cmp_vld_d     = t_vld & ~clr;
      prod_d        = PW'(t_a) * PW'(t_b);
      res_d         = mul_r;
      diff_d        = $signed({1'b0, mul_r}) - $signed({1'b0, prod_d});
      abs_err       = MAX_ERR_W'(diff_q[DW-1] ? -diff_q : diff_q);
      err_count_d   = err_count_q;
      sum_abs_err_d = sum_abs_err_q;
      max_abs_err_d = max_abs_err_q;
      sum_err_d     = sum_err_q;
      if (clr) begin
         err_count_d   = '0;
         sum_abs_err_d = '0;
         max_abs_err_d = '0;
         sum_err_d     = '0;
      end else if (cmp_vld_q) begin
         err_count_d   = err_count_q + ERR_CNT_W'(res_q != prod_q);
         sum_abs_err_d = sum_abs_err_q + SUM_ABS_W'(abs_err);
         max_abs_err_d = (abs_err > max_abs_err_q) ? abs_err : max_abs_err_q;
         sum_err_d     = sum_err_q + {{(SUM_ERR_W-DW){diff_q[DW-1]}}, diff_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_vld_q     <= 1'b0;
         prod_q        <= '0;
         res_q         <= '0;
         diff_q        <= '0;
         err_count_q   <= '0;
         sum_abs_err_q <= '0;
         max_abs_err_q <= '0;
         sum_err_q     <= '0;
      end else begin
         cmp_vld_q     <= cmp_vld_d;
         prod_q        <= prod_d;
         res_q         <= res_d;
         diff_q        <= diff_d;
         err_count_q   <= err_count_d;
         sum_abs_err_q <= sum_abs_err_d;
         max_abs_err_q <= max_abs_err_d;
         sum_err_q     <= sum_err_d;
      end
   end

   assign err_count   = err_count_q;
   assign sum_abs_err = sum_abs_err_q;
   assign max_abs_err = max_abs_err_q;
   assign sum_err     = sum_err_q;
endmodule

// File: rtl/approx_err_sweep.sv
// approx_err_sweep: drives all 256 4x4 operand pairs into an external multiplier
// and reports error statistics of its results against the exact product.
module approx_err_sweep
   import approx_err_sweep_pkg::*;
#(
   parameter int DUT_LAT = 0,
   parameter int W       = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic [W-1:0]                mul_a,
   output logic [W-1:0]                mul_b,
   input  logic [2*W-1:0]              mul_r,
   output logic                        busy,
   output logic                        done,
   output logic [ERR_CNT_W-1:0]        err_count,
   output logic [SUM_ABS_W-1:0]        sum_abs_err,
   output logic [MAX_ERR_W-1:0]        max_abs_err,
   output logic signed [SUM_ERR_W-1:0] sum_err
);
   state_e             state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [DRAIN_W-1:0] drain_d, drain_q;
   logic               clr, sweep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

   // DRAIN covers the multiplier latency plus the compare and accumulate stages
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      clr     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            clr     = 1'b1;
            cnt_d   = '0;
            state_d = SWEEP;
         end
         SWEEP: if (cnt_q == CNT_W'(N_PAIRS - 1)) begin
            state_d = DRAIN;
            drain_d = '0;
         end else cnt_d = cnt_q + 1'b1;
         DRAIN: if (drain_q == DRAIN_W'(DUT_LAT + 1)) state_d = FIN;
                else drain_d = drain_q + 1'b1;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign sweep = state_q == SWEEP;
   assign busy  = sweep || state_q == DRAIN;
   assign done  = state_q == FIN;
   assign mul_a = sweep ? cnt_q[W-1:0] : '0;
   assign mul_b = sweep ? cnt_q[2*W-1:W] : '0;

   err_accum #(.LAT(DUT_LAT), .W(W)) u_err_accum (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_vld     (sweep),
      .in_a       (mul_a),
      .in_b       (mul_b),
      .mul_r      (mul_r),
      .err_count  (err_count),
      .sum_abs_err(sum_abs_err),
      .max_abs_err(max_abs_err),
      .sum_err    (sum_err)
   );
endmodule

// File: tb/tb_approx_err_sweep.sv
// tb_approx_err_sweep: directed sweeps on a zero-latency and a two-cycle-latency
// instance with a scoreboard of expected statistics per sweep.
module tb_approx_err_sweep;
   typedef struct {int ec; int sa; int mx; int se;} exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0, start2 = 1'b0;
   logic sel = 1'b0;
   int   mode = 0;
   logic [3:0] a0, b0, a2, b2;
   logic [7:0] r0, r2;
   logic [7:0] p1 = '0, p2 = '0;
   logic busy0, done0, busy2, done2;
   logic [8:0] ec0, ec2;
   logic [15:0] sa0, sa2;
   logic [7:0] mx0, mx2;
   logic signed [16:0] se0, se2;
   logic s_busy, s_done;
   logic [3:0] s_a, s_b;
   logic [8:0] s_ec;
   logic [15:0] s_sa;
   logic [7:0] s_mx;
   logic signed [16:0] s_se;
   int vectors = 0, miscompares = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   approx_err_sweep #(.DUT_LAT(0), .W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .mul_a(a0), .mul_b(b0), .mul_r(r0),
      .busy(busy0), .done(done0), .err_count(ec0), .sum_abs_err(sa0),
      .max_abs_err(mx0), .sum_err(se0)
   );

   approx_err_sweep #(.DUT_LAT(2), .W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .mul_a(a2), .mul_b(b2), .mul_r(r2),
      .busy(busy2), .done(done2), .err_count(ec2), .sum_abs_err(sa2),
      .max_abs_err(mx2), .sum_err(se2)
   );

   function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
      return {4'b0, a} * {4'b0, b};
   endfunction

   function automatic logic [7:0] approx(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = prod(a, b);
      return (p & 8'hFC) | {7'b0, a[0] ^ b[0]};
   endfunction

   always_comb r0 = (mode == 0) ? prod(a0, b0) : (mode == 1) ? 8'h00 : approx(a0, b0);
   always @(posedge clk) begin
      p1 <= prod(a2, b2);
      p2 <= p1;
   end
   assign r2 = p2;

   always_comb begin
      s_busy = sel ? busy2 : busy0;
      s_done = sel ? done2 : done0;
      s_a    = sel ? a2 : a0;
      s_b    = sel ? b2 : b0;
      s_ec   = sel ? ec2 : ec0;
      s_sa   = sel ? sa2 : sa0;
      s_mx   = sel ? mx2 : mx0;
      s_se   = sel ? se2 : se0;
   end

   function automatic exp_t model(input int m);
      exp_t e;
      int p, r, d, ad;
      e = '{0, 0, 0, 0};
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            p = a * b;
            r = (m == 0) ? p : (m == 1) ? 0 : int'(approx(4'(a), 4'(b)));
            d = r - p;
            ad = (d < 0) ? -d : d;
            if (d != 0) e.ec++;
            e.sa += ad;
            if (ad > e.mx) e.mx = ad;
            e.se += d;
         end
      return e;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start2 = v;
      else start0 = v;
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_busy"}, s_busy, 0);
      check({pfx, "_done"}, s_done, 0);
      check({pfx, "_mul_a"}, s_a, 0);
      check({pfx, "_mul_b"}, s_b, 0);
      check({pfx, "_err_count"}, s_ec, 0);
      check({pfx, "_sum_abs_err"}, s_sa, 0);
      check({pfx, "_max_abs_err"}, s_mx, 0);
      check({pfx, "_sum_err"}, s_se, 0);
   endtask

   task automatic run(input logic which, input int m, input int restart_at, input int lat);
      exp_t e;
      int n, dones;
      sel = which;
      mode = m;
      if (m == 0) sb.push_back('{0, 0, 0, 0});
      else if (m == 1) sb.push_back('{225, 14400, 225, -14400});
      else sb.push_back(model(m));
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      n = 1;
      check("busy_first", s_busy, 1);
      check("clear_on_start", s_sa, 0);
      check("mul_a_first", s_a, 0);
      while (!s_done && n < 400) begin
         if (n == 18) begin
            check("mul_a_c18", s_a, 1);
            check("mul_b_c18", s_b, 1);
         end
         if (n == 256) check("mul_b_last", s_b, 15);
         if (n == 257) check("mul_a_drain", s_a, 0);
         set_start(n == restart_at);
         @(negedge clk);
         n++;
      end
      set_start(1'b0);
      e = sb.pop_front();
      check("latency", n, lat);
      check("busy_at_done", s_busy, 0);
      check("err_count", s_ec, e.ec);
      check("sum_abs_err", s_sa, e.sa);
      check("max_abs_err", s_mx, e.mx);
      check("sum_err", s_se, e.se);
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         dones += int'(s_done);
      end
      check("extra_done", dones, 0);
      check("hold_err_count", s_ec, e.ec);
      check("hold_sum_err", s_se, e.se);
      check("idle_mul_a", s_a, 0);
   endtask

   initial begin
      int dones;
      repeat (2) @(negedge clk);
      sel = 1'b0;
      check_outputs_zero("rst0");
      sel = 1'b1;
      check_outputs_zero("rst2");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(1'b0, 0, 0, 259);
      run(1'b0, 1, 0, 259);
      run(1'b0, 2, 0, 259);
      run(1'b1, 0, 0, 261);
      run(1'b0, 2, 100, 259);

      sel = 1'b0;
      mode = 1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (49) @(negedge clk);
      check("pre_reset_err_nonzero", s_ec != 0, 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      dones = 0;
      repeat (4) begin
         @(negedge clk);
         dones += int'(s_done);
      end
      rst_n = 1'b1;
      repeat (300) begin
         @(negedge clk);
         dones += int'(s_done);
      end
      check("abort_no_done", dones, 0);
      check("abort_idle_busy", s_busy, 0);

      run(1'b0, 2, 0, 259);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
